weight_medium_arbiter: RTL



---
 rtl/weight_medium_arbiter_if.sv | 51 +++++
 rtl/weight_medium_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/weight_medium_arbiter_if.sv
// Signal bundle between the weight-medium arbiter and its neighbours (CPU, host loader, BRAM).
// slave is the arbiter's view; master is the surrounding system's view.
interface weight_medium_arbiter_if #(
  parameter int WEIGHT_LENGTH = 256,
  parameter int W_SIZE        = 1024
);
  localparam int A_SIZE = $clog2(WEIGHT_LENGTH);

  logic [A_SIZE-1:0] cpu_addr_in;
  logic [W_SIZE-1:0] cpu_data_in;
  logic              cpu_read_enable_in;
  logic              cpu_write_enable_in;
  logic [W_SIZE-1:0] cpu_data_out;
  logic              cpu_finished_out;

  logic              host_req_in;
  logic              host_we_in;
  logic [A_SIZE-1:0] host_addr_in;
  logic [W_SIZE-1:0] host_wdata_in;
  logic              host_gnt_out;
  logic [W_SIZE-1:0] host_rdata_out;
  logic              host_rvalid_out;

  logic [A_SIZE-1:0] bram_addr_out;
  logic [W_SIZE-1:0] bram_din_out;
  logic              bram_we_out;
  logic              bram_en_out;
  logic [W_SIZE-1:0] bram_dout_in;

  logic              busy_out;

  modport slave (
    input  cpu_addr_in, cpu_data_in, cpu_read_enable_in, cpu_write_enable_in,
    output cpu_data_out, cpu_finished_out,
    input  host_req_in, host_we_in, host_addr_in, host_wdata_in,
    output host_gnt_out, host_rdata_out, host_rvalid_out,
    output bram_addr_out, bram_din_out, bram_we_out, bram_en_out,
    input  bram_dout_in,
    output busy_out
  );

  modport master (
    output cpu_addr_in, cpu_data_in, cpu_read_enable_in, cpu_write_enable_in,
    input  cpu_data_out, cpu_finished_out,
    output host_req_in, host_we_in, host_addr_in, host_wdata_in,
    input  host_gnt_out, host_rdata_out, host_rvalid_out,
    input  bram_addr_out, bram_din_out, bram_we_out, bram_en_out,
    output bram_dout_in,
    input  busy_out
  );
endinterface

// File: rtl/weight_medium_arbiter.sv
// Shares one single-port weight BRAM between the CPU weight-medium port and a host loader,
// round-robin on ties, with timed reads and one-cycle completion pulses.
module weight_medium_arbiter #(
  parameter int WEIGHT_LENGTH = 256,
  parameter int W_SIZE        = 1024,
  parameter int READ_LATENCY  = 2
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  weight_medium_arbiter_if.slave bus
);
  localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t     state;
  logic       cpu_pending, cpu_pend_we;
  logic       last_host, owner_host;
  logic [2:0] cnt;

  logic cpu_pulse, cpu_req, cpu_we_eff, pick_cpu;

  // A pulse landing in IDLE competes on the same edge it is latched.
  always_comb begin
    cpu_pulse  = bus.cpu_read_enable_in | bus.cpu_write_enable_in;
    cpu_req    = cpu_pending | cpu_pulse;
    cpu_we_eff = cpu_pending ? cpu_pend_we : bus.cpu_write_enable_in;
    pick_cpu   = cpu_req & (~bus.host_req_in | last_host);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                <= S_IDLE;
      cpu_pending          <= 1'b0;
      cpu_pend_we          <= 1'b0;
      last_host            <= 1'b1;
      owner_host           <= 1'b0;
      cnt                  <= '0;
      bus.cpu_data_out     <= '0;
      bus.cpu_finished_out <= 1'b0;
      bus.host_gnt_out     <= 1'b0;
      bus.host_rdata_out   <= '0;
      bus.host_rvalid_out  <= 1'b0;
      bus.bram_addr_out    <= '0;
      bus.bram_din_out     <= '0;
      bus.bram_we_out      <= 1'b0;
      bus.bram_en_out      <= 1'b0;
      bus.busy_out         <= 1'b0;
    end else begin
      bus.cpu_finished_out <= 1'b0;
      bus.host_rvalid_out  <= 1'b0;
      if (!cpu_pending && cpu_pulse) begin
        cpu_pending <= 1'b1;
        cpu_pend_we <= bus.cpu_write_enable_in;
      end
      case (state)
        S_IDLE: begin
          if (cpu_req || bus.host_req_in) begin
            owner_host        <= ~pick_cpu;
            last_host         <= ~pick_cpu;
            bus.bram_addr_out <= pick_cpu ? bus.cpu_addr_in : bus.host_addr_in;
            bus.bram_din_out  <= pick_cpu ? bus.cpu_data_in : bus.host_wdata_in;
            bus.bram_we_out   <= pick_cpu ? cpu_we_eff : bus.host_we_in;
            bus.bram_en_out   <= 1'b1;
            bus.host_gnt_out  <= ~pick_cpu;
            bus.busy_out      <= 1'b1;
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // bram_we_out still carries the op type during this cycle.
          bus.bram_en_out  <= 1'b0;
          bus.bram_we_out  <= 1'b0;
          bus.host_gnt_out <= 1'b0;
          cnt              <= '0;
          if (bus.bram_we_out) begin
            state        <= S_IDLE;
            bus.busy_out <= 1'b0;
            if (!owner_host) begin
              bus.cpu_finished_out <= 1'b1;
              cpu_pending          <= 1'b0;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == LAST_CNT) begin
            state        <= S_IDLE;
            bus.busy_out <= 1'b0;
            if (owner_host) begin
              bus.host_rdata_out  <= bus.bram_dout_in;
              bus.host_rvalid_out <= 1'b1;
            end else begin
              bus.cpu_data_out     <= bus.bram_dout_in;
              bus.cpu_finished_out <= 1'b1;
              cpu_pending          <= 1'b0;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
